// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
package rf_pkg;

   // Sweep FSM: SWEEP clears entries one per cycle, READY serves reads and writes
   typedef enum logic {
      RF_SWEEP = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int RF_WR_PORTS = 2;  // write-back ports: 0 = main WB, 1 = load WB
   localparam int RF_ZERO_REG = 0;  // hardwired-zero register index

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux, zero-register and busy gating.
// Optional same-cycle write forwarding when RF_BYPASS_EN is defined.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                                   busy,
   input  logic [ADDR_W-1:0]                      raddr,
   input  logic [DATA_W-1:0]                      entries [DEPTH],
   input  logic [RF_WR_PORTS-1:0]                 we,
   input  logic [RF_WR_PORTS-1:0][ADDR_W-1:0]     waddr,
   input  logic [RF_WR_PORTS-1:0][DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]                      rdata
);

   // Read mux; later write ports override earlier ones, gating to zero last
   always_comb begin
      rdata = entries[raddr];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < RF_WR_PORTS; p++) begin
         if (we[p] && (waddr[p] == raddr)) rdata = wdata[p];
      end
`endif
      if (busy || (raddr == ADDR_W'(RF_ZERO_REG))) rdata = '0;
   end

`ifndef RF_BYPASS_EN
   // Forwarding inputs only matter when bypass is built in
   logic unused_bypass;
   assign unused_bypass = ^{we, waddr, wdata};
`endif

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD async reads, 2 write ports, entry 0 = zero.
// Contents are cleared by a post-reset/clear_req sweep (one entry per cycle)
// so the array itself needs no reset and can map to distributed RAM.
// Optional: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear_req,
   output logic                       busy,
   input  logic [1:0]                 we,
   input  logic [2*ADDR_W-1:0]        waddr,
   input  logic [2*DATA_W-1:0]        wdata,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata
);

   localparam int DEPTH = 2**ADDR_W;

   rf_state_e                               state_q, state_d;
   logic [ADDR_W-1:0]                       sweep_ptr;
   logic [DATA_W-1:0]                       mem [DEPTH];
   logic [RF_WR_PORTS-1:0][ADDR_W-1:0]      wa;
   logic [RF_WR_PORTS-1:0][DATA_W-1:0]      wd;
   logic [RF_WR_PORTS-1:0]                  wr_en;

   assign wa = waddr;
   assign wd = wdata;

   // State register: reset lands in SWEEP so storage is always cleared first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RF_SWEEP;
      else        state_q <= state_d;
   end

   // Next state: leave SWEEP after the last entry, re-enter on clear_req
   always_comb begin
      state_d = state_q;
      case (state_q)
         RF_SWEEP: if (sweep_ptr == ADDR_W'(DEPTH-1)) state_d = RF_READY;
         RF_READY: if (clear_req) state_d = RF_SWEEP;
         default:  state_d = RF_SWEEP;
      endcase
   end

   // Outputs: busy for the whole sweep
   always_comb begin
      busy = (state_q == RF_SWEEP);
   end

   // Sweep pointer: walks 1..DEPTH-1, restarts at 1 on any new sweep
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   sweep_ptr <= ADDR_W'(1);
      else if (state_q == RF_SWEEP) sweep_ptr <= sweep_ptr + ADDR_W'(1);
      else if (clear_req)           sweep_ptr <= ADDR_W'(1);
   end

   // Write qualification: READY only, zero register never written
   always_comb begin
      for (int p = 0; p < RF_WR_PORTS; p++)
         wr_en[p] = we[p] && (state_q == RF_READY) && (wa[p] != ADDR_W'(RF_ZERO_REG));
   end

   // Storage: sweep clears one entry, otherwise ports commit in order so port 1 wins.
   // Gating on reset level aborts any write landing while reset is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state_q == RF_SWEEP) begin
            mem[sweep_ptr] <= '0;
         end else begin
            for (int p = 0; p < RF_WR_PORTS; p++)
               if (wr_en[p]) mem[wa[p]] <= wd[p];
         end
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_rd (
         .busy    (busy),
         .raddr   (raddr[r*ADDR_W +: ADDR_W]),
         .entries (mem),
         .we      (we),
         .waddr   (wa),
         .wdata   (wd),
         .rdata   (rdata[r*DATA_W +: DATA_W])
      );
   end

endmodule
